// File: rtl/clock_mode_controller.sv
// Mode sequencer for the 24-hour clock: time/alarm edit flow, load handshake
// into the clock counter, edit timeout, field blink and alarm ring control.
module clock_mode_controller #(
  parameter int TIMEOUT_S    = 30,
  parameter int RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic [2:0] mode,
  output logic       blink,
  output logic       alarm_on,
  output logic       ringing
);

  typedef enum logic [2:0] {
    CLOCK = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    ALM_H = 3'd3,
    ALM_M = 3'd4
  } mode_e;

  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam int RW = $clog2(RING_SECONDS + 1);

  mode_e         state;
  logic [4:0]    alarm_hours;
  logic [5:0]    alarm_minutes;
  logic [IW-1:0] idle_cnt;
  logic [RW-1:0] ring_cnt;
  logic          match_q;

  logic       any_btn, match, match_edge, consumed, edit_state;
  logic [4:0] hours_inc, hours_dec;
  logic [5:0] mins_inc, mins_dec;

  assign mode       = state;
  assign any_btn    = btn_set | btn_up | btn_down;
  // While ringing, a button only silences the alarm.
  assign consumed   = ringing & any_btn;
  assign edit_state = (state != CLOCK);

  assign hours_inc = (edit_hours == 5'd23)   ? 5'd0  : edit_hours + 5'd1;
  assign hours_dec = (edit_hours == 5'd0)    ? 5'd23 : edit_hours - 5'd1;
  assign mins_inc  = (edit_minutes == 6'd59) ? 6'd0  : edit_minutes + 6'd1;
  assign mins_dec  = (edit_minutes == 6'd0)  ? 6'd59 : edit_minutes - 6'd1;

  assign match = alarm_on && (cur_hours == alarm_hours) &&
                 (cur_minutes == alarm_minutes) && (cur_seconds == 6'd0);
  // Edge, not level: a match held for the whole second fires only once.
  assign match_edge = match & ~match_q;

  // Alarm ring: start on match edge, stop on timeout or any button pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_q  <= 1'b0;
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else begin
      match_q <= match;
      if (match_edge) begin
        ringing  <= 1'b1;
        ring_cnt <= '0;
      end else if (ringing) begin
        if (any_btn) begin
          ringing <= 1'b0;
        end else if (tick) begin
          if (ring_cnt == RW'(RING_SECONDS - 1)) begin
            ringing  <= 1'b0;
            ring_cnt <= '0;
          end else begin
            ring_cnt <= ring_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Mode FSM with edit fields, load strobe, alarm storage, timeout and blink.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= CLOCK;
      edit_hours    <= '0;
      edit_minutes  <= '0;
      load          <= 1'b0;
      load_hours    <= '0;
      load_minutes  <= '0;
      alarm_hours   <= '0;
      alarm_minutes <= '0;
      alarm_on      <= 1'b0;
      blink         <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      load <= 1'b0;
      if (consumed) begin
        idle_cnt <= '0;
      end else if (btn_set) begin
        idle_cnt <= '0;
        case (state)
          CLOCK: begin
            state        <= SET_H;
            edit_hours   <= cur_hours;
            edit_minutes <= cur_minutes;
            blink        <= 1'b1;
          end
          SET_H: begin
            state <= SET_M;
            blink <= 1'b1;
          end
          SET_M: begin
            state        <= ALM_H;
            load         <= 1'b1;
            load_hours   <= edit_hours;
            load_minutes <= edit_minutes;
            edit_hours   <= alarm_hours;
            edit_minutes <= alarm_minutes;
            blink        <= 1'b1;
          end
          ALM_H: begin
            state <= ALM_M;
            blink <= 1'b1;
          end
          default: begin
            state         <= CLOCK;
            alarm_hours   <= edit_hours;
            alarm_minutes <= edit_minutes;
            alarm_on      <= 1'b1;
            blink         <= 1'b0;
          end
        endcase
      end else if (btn_up) begin
        idle_cnt <= '0;
        case (state)
          CLOCK:        alarm_on <= ~alarm_on;
          SET_H, ALM_H: begin edit_hours   <= hours_inc; blink <= 1'b1; end
          default:      begin edit_minutes <= mins_inc;  blink <= 1'b1; end
        endcase
      end else if (btn_down) begin
        idle_cnt <= '0;
        case (state)
          CLOCK:        ;
          SET_H, ALM_H: begin edit_hours   <= hours_dec; blink <= 1'b1; end
          default:      begin edit_minutes <= mins_dec;  blink <= 1'b1; end
        endcase
      end else if (edit_state && tick) begin
        // Abandon the edit silently: no load, alarm storage untouched.
        if (idle_cnt == IW'(TIMEOUT_S - 1)) begin
          state    <= CLOCK;
          idle_cnt <= '0;
          blink    <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
          blink    <= ~blink;
        end
      end
    end
  end

endmodule

// File: doc/clock_mode_controller.md
# clock_mode_controller

Mode sequencer for the 24-hour clock datapath. It consumes debounced, pulsed set/up/down button strobes and a 1 Hz tick enable, and runs the time-edit and alarm-edit flow. It drives the load handshake (load strobe plus hours/minutes) into the running clock counter, and raises the alarm ring. It sits between the button front-end (debouncer + pulse generator) and the clock counter / display mux; its `mode` output selects the display source.

## Interface
- `TIMEOUT_S`, 30: ticks without a button press before an edit state is abandoned.
- `RING_SECONDS`, 60: ticks the alarm rings unless cancelled.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `tick` in 1: one-cycle 1 Hz enable, synchronous to `clk`.
- `btn_set`, `btn_up`, `btn_down` in 1 each: one-cycle button pulses.
- `cur_hours` in 5, `cur_minutes` in 6, `cur_seconds` in 6: live clock counter value.
- `load` out 1: one-cycle strobe; the clock counter adopts `load_hours`/`load_minutes` and zeroes its seconds.
- `load_hours` out 5, `load_minutes` out 6: value presented with `load`.
- `edit_hours` out 5, `edit_minutes` out 6: value being edited, for the set-display decoder.
- `mode` out 3: 0 CLOCK, 1 SET_H, 2 SET_M, 3 ALM_H, 4 ALM_M.
- `blink` out 1: field-blink phase for the edited field.
- `alarm_on` out 1: alarm armed.
- `ringing` out 1: alarm active.

## Operation
- **State sequence:** `btn_set` advances CLOCK→SET_H→SET_M→ALM_H→ALM_M→CLOCK.
- **CLOCK→SET_H:** `edit_hours`/`edit_minutes` ← `cur_hours`/`cur_minutes`.
- **SET_M→ALM_H:**
  - `load` pulses with `load_*` ← `edit_*`.
  - Then `edit_*` ← stored alarm time.
- **ALM_M→CLOCK:** stored alarm ← `edit_*`; `alarm_on` ← 1.
- **In CLOCK:** `btn_up` toggles `alarm_on`; `btn_down` is ignored.
- **Field adjust:**
  - In SET_H/ALM_H, up/down adjust hours with wrap (23→0 on up, 0→23 on down).
  - In SET_M/ALM_M, up/down adjust minutes with wrap (59→0, 0→59).
  - No carry between fields.
- **Simultaneous buttons:** priority set > up > down; at most one action per cycle.
- **Timeout:**
  - Idle counter clears on any button pulse and on entering an edit state; it increments on `tick` in edit states.
  - On reaching `TIMEOUT_S`, return to CLOCK.
  - No `load`, alarm unchanged, `alarm_on` unchanged.
- **Blink:**
  - Set to 1 on entering an edit state and on any up/down press.
  - Toggles on each `tick` while in an edit state.
  - Forced 0 in CLOCK.
- **Alarm match:** `alarm_on` && `cur_hours`==alarm hours && `cur_minutes`==alarm minutes && `cur_seconds`==0.
- **Ring start:** a registered rising edge of the match sets `ringing` and clears the ring counter. Ringing can start in any state.
- **Ring end:**
  - Ring counter increments on `tick`; `ringing` clears at `RING_SECONDS`.
  - Alternatively, any button pulse clears `ringing`. That pulse is consumed: no state change, no field adjust, no `alarm_on` toggle.
- **Disarm:** clearing `alarm_on` (CLOCK, up, while not ringing) suppresses future matches.
- **Reset values:**
  - mode=0, `edit_*`=0, `load`=0, `load_*`=0.
  - Alarm time 00:00, `alarm_on`=0, `ringing`=0, `blink`=0.
  - Idle/ring counters 0, match-edge register 0.

## Timing
- All outputs registered. A button pulse in cycle N produces the `mode`/`edit_*`/`blink` update visible in cycle N+1.
- `load` is high for exactly cycle N+1 after the SET_M `btn_set` pulse. `load_*` becomes valid in N+1 and holds until the next `load`.
- Timeout: the `TIMEOUT_S`-th idle tick in cycle T gives mode=0 in T+1.
- Ring: a match edge in cycle M gives `ringing`=1 in M+1. The `RING_SECONDS`-th tick gives `ringing`=0 on the next cycle.
- Match must hold a full second to re-fire only once: edge detect, not level.
- Reset asserted mid-edit: immediate return to reset values; no `load` is emitted.

## Test plan
- **Set time:** reset, then set, up×3 (hours 0→3), set, down×1 (minutes 0→59), set → `load`=1 for one cycle with 03:59; mode=3 next.
- **Set alarm:** continue from ALM_H with up×7, set, up×30, set → alarm 07:30, `alarm_on`=1, mode=0.
- **Alarm ring:** alarm armed at 07:30; drive `cur` 07:29:59→07:30:00 → `ringing`=1 next cycle. 60 ticks → `ringing`=0. Holding 07:30:00 does not re-fire.
- **Cancel ring:** press up while ringing → `ringing`=0, `alarm_on` stays 1, mode unchanged.
- **Timeout:** enter SET_H, apply 30 ticks with no button → mode=0, no `load`. At 29 ticks plus an up press, the counter restarts.
- **Wrap, priority, async reset:**
  - At hours 23, up → 0.
  - Set+up in the same cycle → only the state advances.
  - Reset asserted mid-SET_M → all outputs to reset values asynchronously.
